alu_md_control: RTL and testbench

//  Next-gen ALU control for the EX stage. Decodes ALUOp/funct3/funct7 into the 4-bit ALU op, as the single-cycle decoder does,
//  and adds RV32M (funct7=0000001). MUL*/DIV*/REM* execute in an internal multi-cycle multiply/divide unit (MDU).

---
 rtl/alu_ctrl_pkg.sv | 69 ++++++
 rtl/alu_md_control_if.sv | 26 ++
 rtl/md_divider.sv | 54 +++++
 rtl/alu_md_control.sv | 169 ++++++++++++++++
 tb/tb_alu_md_control.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// ALU control package: ALU op codes, funct7 classes, MDU state encoding and the base decoder.
package alu_ctrl_pkg;

  localparam int unsigned XLEN_DEFAULT        = 32;
  localparam int unsigned MUL_LATENCY_DEFAULT = 2;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_MDU  = 4'b1010,
    ALU_ERR  = 4'b1111
  } alu_op_e;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;
  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  // ALUOp/funct3/funct7 to ALU op; any funct7 other than ALT/MEXT decodes as the base op.
  function automatic alu_op_e alu_decode(input logic [1:0] alu_op, input logic [2:0] funct3,
                                         input logic [6:0] funct7);
    alu_op_e op;
    logic    alt;
    alt = (funct7 == FUNCT7_ALT);
    op  = ALU_ERR;
    case (alu_op)
      ALUOP_ADD: op = ALU_ADD;
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_RTYPE: begin
        if (funct7 == FUNCT7_MEXT) begin
          op = ALU_MDU;
        end else begin
          case (funct3)
            3'b000: op = alt ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = alt ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
            default: op = ALU_ERR;
          endcase
        end
      end
      default: op = ALU_ERR;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_md_control_if.sv
// EX-stage bus between the pipeline (master) and the ALU/MDU control block (slave).
interface alu_md_control_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            flush;
  logic            in_valid;
  logic [1:0]      ALUOp;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [3:0]      alu_control;
  logic            stall;
  logic            md_done;
  logic [XLEN-1:0] md_result;

  modport master (
    output flush, in_valid, ALUOp, funct3, funct7, op_a, op_b,
    input  alu_control, stall, md_done, md_result
  );

  modport slave (
    input  flush, in_valid, ALUOp, funct3, funct7, op_a, op_b,
    output alu_control, stall, md_done, md_result
  );
endinterface

// File: rtl/md_divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle for XLEN cycles.
// o_done_c flags the final iteration; o_quo_c/o_rem_c are the post-step values in that cycle.
module md_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_abort,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done_c,
  output logic [XLEN-1:0] o_quo_c,
  output logic [XLEN-1:0] o_rem_c
);
  localparam int unsigned CNT_W = $clog2(XLEN + 1);

  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN:0]    w_shift;
  logic [XLEN:0]    w_trial;
  logic             w_fits;

  // One restoring step: shift in the next dividend bit, subtract if the divisor fits.
  always_comb begin
    w_shift  = {r_rem, r_quo[XLEN-1]};
    w_trial  = w_shift - {1'b0, r_dvs};
    w_fits   = ~w_trial[XLEN];
    o_rem_c  = w_fits ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
    o_quo_c  = {r_quo[XLEN-2:0], w_fits};
    o_done_c = (r_cnt == CNT_W'(1));
  end

  // Iteration state; abort simply drops the remaining count.
  always_ff @(posedge clk) begin
    if (reset || i_abort) begin
      r_cnt <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
    end else if (i_start) begin
      r_cnt <= CNT_W'(XLEN);
      r_quo <= i_dividend;
      r_rem <= '0;
      r_dvs <= i_divisor;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
      r_quo <= o_quo_c;
      r_rem <= o_rem_c;
    end
  end
endmodule

// File: rtl/alu_md_control.sv
// EX-stage ALU control with an RV32M multi-cycle multiply/divide unit.
// Optional: define DIV_EARLY_OUT_EN to finish divide-by-zero and signed overflow in one cycle.
module alu_md_control
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN        = XLEN_DEFAULT,
  parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  alu_md_control_if.slave     bus
);
  localparam int unsigned CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  md_state_e        r_state, w_state_nxt;
  alu_op_e          w_alu_op;
  logic             w_md_start;
  logic             w_div_start;
  logic             w_div_last;
  logic             w_div_signed;
  logic [XLEN-1:0]  w_mag_a, w_mag_b;
  logic [XLEN-1:0]  w_quo, w_rem;
  logic             w_load_result;
  logic [XLEN-1:0]  w_result_nxt;
  logic [XLEN-1:0]  r_op_a, r_op_b;
  logic [1:0]       r_md_sel;
  logic [CNT_W-1:0] r_mul_cnt;
  logic [XLEN-1:0]  r_md_result;
  logic             r_md_done;

  // MUL/MULH/MULHSU/MULHU from a 2*XLEN product of sign/zero-extended operands.
  function automatic logic [XLEN-1:0] mul_result(input logic [1:0] sel, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] ea, eb, prod;
    logic              sa, sb;
    sa   = (sel == 2'b01) || (sel == 2'b10);
    sb   = (sel == 2'b01);
    ea   = {{XLEN{sa & a[XLEN-1]}}, a};
    eb   = {{XLEN{sb & b[XLEN-1]}}, b};
    prod = ea * eb;
    return (sel == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

  // Sign fix of magnitude quotient/remainder plus the divide-by-zero and overflow results.
  function automatic logic [XLEN-1:0] div_fixup(input logic [1:0] sel, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b, input logic [XLEN-1:0] q,
                                                input logic [XLEN-1:0] r);
    logic            sgn, is_rem;
    logic [XLEN-1:0] min_v, res;
    sgn    = ~sel[0];
    is_rem = sel[1];
    min_v  = {1'b1, {(XLEN-1){1'b0}}};
    if (b == '0)                              res = is_rem ? a : '1;
    else if (sgn && (a == min_v) && (b == '1)) res = is_rem ? '0 : min_v;
    else if (is_rem)                          res = (sgn & a[XLEN-1]) ? -r : r;
    else                                      res = (sgn & (a[XLEN-1] ^ b[XLEN-1])) ? -q : q;
    return res;
  endfunction

  // Decode and start qualification.
  always_comb begin
    w_alu_op     = alu_decode(bus.ALUOp, bus.funct3, bus.funct7);
    w_md_start   = bus.in_valid & (w_alu_op == ALU_MDU) & (r_state == MD_IDLE) & ~bus.flush & ~reset;
    w_div_signed = ~bus.funct3[0];
    w_mag_a      = (w_div_signed & bus.op_a[XLEN-1]) ? -bus.op_a : bus.op_a;
    w_mag_b      = (w_div_signed & bus.op_b[XLEN-1]) ? -bus.op_b : bus.op_b;
  end

`ifdef DIV_EARLY_OUT_EN
  logic w_div_special;
  assign w_div_special = (bus.op_b == '0) |
                         (w_div_signed & (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) & (bus.op_b == '1));
`endif

  assign bus.alu_control = w_alu_op;
  assign bus.stall       = ~reset & (w_md_start | (r_state == MD_MUL) | (r_state == MD_DIV));
  assign bus.md_done     = r_md_done;
  assign bus.md_result   = r_md_result;

  md_divider #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .reset      (reset),
    .i_abort    (bus.flush),
    .i_start    (w_div_start),
    .i_dividend (w_mag_a),
    .i_divisor  (w_mag_b),
    .o_done_c   (w_div_last),
    .o_quo_c    (w_quo),
    .o_rem_c    (w_rem)
  );

  // MDU state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= MD_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, divider start and result load; reset/flush abort without a result.
  always_comb begin
    w_state_nxt   = r_state;
    w_div_start   = 1'b0;
    w_load_result = 1'b0;
    w_result_nxt  = r_md_result;
    case (r_state)
      MD_IDLE: begin
        if (w_md_start) begin
          if (!bus.funct3[2]) begin
            w_state_nxt = MD_MUL;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (w_div_special) begin
            w_state_nxt   = MD_DONE;
            w_load_result = 1'b1;
            w_result_nxt  = div_fixup(bus.funct3[1:0], bus.op_a, bus.op_b, '0, '0);
          end
`endif
          else begin
            w_state_nxt = MD_DIV;
            w_div_start = 1'b1;
          end
        end
      end
      MD_MUL: begin
        if (r_mul_cnt == '0) begin
          w_state_nxt   = MD_DONE;
          w_load_result = 1'b1;
          w_result_nxt  = mul_result(r_md_sel, r_op_a, r_op_b);
        end
      end
      MD_DIV: begin
        if (w_div_last) begin
          w_state_nxt   = MD_DONE;
          w_load_result = 1'b1;
          w_result_nxt  = div_fixup(r_md_sel, r_op_a, r_op_b, w_quo, w_rem);
        end
      end
      MD_DONE: w_state_nxt = MD_IDLE;
      default: w_state_nxt = MD_IDLE;
    endcase
    if (reset || bus.flush) begin
      w_state_nxt   = MD_IDLE;
      w_div_start   = 1'b0;
      w_load_result = 1'b0;
    end
  end

  // Operand latch, multiply countdown and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_md_sel    <= '0;
      r_mul_cnt   <= '0;
      r_md_result <= '0;
      r_md_done   <= 1'b0;
    end else begin
      r_md_done <= (w_state_nxt == MD_DONE);
      if (w_load_result) r_md_result <= w_result_nxt;
      if (w_md_start) begin
        r_op_a    <= bus.op_a;
        r_op_b    <= bus.op_b;
        r_md_sel  <= bus.funct3[1:0];
        r_mul_cnt <= CNT_W'(MUL_LATENCY - 1);
      end else if ((r_state == MD_MUL) && (r_mul_cnt != '0)) begin
        r_mul_cnt <= r_mul_cnt - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_alu_md_control.sv
// Self-checking bench for alu_md_control: decode sweep, directed RV32M cases, corners,
// flush/reset abort, back-to-back ops and randomized MDU ops against a reference model.
module tb_alu_md_control;
  localparam int unsigned XLEN   = 32;
  localparam int          MUL_LAT = 2;
  localparam logic [6:0]  F7_BASE = 7'b0000000;
  localparam logic [6:0]  F7_ALT  = 7'b0100000;
  localparam logic [6:0]  F7_MEXT = 7'b0000001;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  alu_md_control_if #(.XLEN(XLEN)) bus ();

  alu_md_control #(.XLEN(XLEN), .MUL_LATENCY(MUL_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference decode: table indexed by funct3, ALT funct7 swaps ADD->SUB and SRL->SRA.
  function automatic logic [3:0] ref_alu(input logic [1:0] aluop, input logic [2:0] f3,
                                         input logic [6:0] f7);
    logic [3:0] tbl [8];
    logic [3:0] r;
    tbl = '{4'h2, 4'h5, 4'h8, 4'h9, 4'h4, 4'h6, 4'h1, 4'h0};
    if (aluop == 2'b00)                       r = 4'h2;
    else if (aluop == 2'b01)                  r = 4'h3;
    else if (aluop == 2'b11)                  r = 4'hF;
    else if (f7 == F7_MEXT)                   r = 4'hA;
    else if (f7 == F7_ALT && f3 == 3'd0)      r = 4'h3;
    else if (f7 == F7_ALT && f3 == 3'd5)      r = 4'h7;
    else                                      r = tbl[f3];
    return r;
  endfunction

  // Reference RV32M result from 64-bit and 32-bit integer arithmetic.
  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub, p;
    int              ia, ib;
    logic            ovf;
    logic [31:0]     r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (f3)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int l;
    if (!f3[2]) l = MUL_LAT + 1;
    else        l = XLEN + 1;
`ifdef DIV_EARLY_OUT_EN
    if (f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) l = 1;
`endif
    return l;
  endfunction

  task automatic drive_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.ALUOp    = 2'b10;
    bus.funct7   = F7_MEXT;
    bus.funct3   = f3;
    bus.op_a     = a;
    bus.op_b     = b;
  endtask

  // Issue one MDU op at t0 and track stall/md_done for a bounded window.
  task automatic md_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int   first = 0;
    int   ndone = 0;
    logic stall_bad = 1'b0;
    drive_md(f3, a, b);
    #1;
    chk({tag, "_alu"}, 32'(bus.alu_control), 32'hA);
    chk({tag, "_stall_t0"}, 32'(bus.stall), 32'd1);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 1) bus.in_valid = 1'b0;
      #1;
      if (bus.md_done) begin
        ndone++;
        if (first == 0) first = k;
      end
      if (bus.stall !== (k < exp_lat)) stall_bad = 1'b1;
    end
    chk({tag, "_lat"}, 32'(first), 32'(exp_lat));
    chk({tag, "_ndone"}, 32'(ndone), 32'd1);
    chk({tag, "_stall"}, 32'(stall_bad), 32'd0);
    chk({tag, "_res"}, bus.md_result, exp);
  endtask

  initial begin
    logic [1:0]  ra;
    logic [2:0]  rf3;
    logic [6:0]  rf7;
    logic [3:0]  ea;
    logic [31:0] a, b, last_res;
    int          ndone;

    reset        = 1'b1;
    bus.flush    = 1'b0;
    drive_md(3'd4, 32'd10, 32'd3);
    tick();
    tick();
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_done", 32'(bus.md_done), 32'd0);
    chk("rst_result", bus.md_result, 32'd0);
    bus.in_valid = 1'b0;
    reset        = 1'b0;
    tick();

    // Base decode directed points, in_valid high to show no stall for non-MDU ops.
    bus.in_valid = 1'b1;
    bus.ALUOp = 2'b10; bus.funct3 = 3'b101; bus.funct7 = F7_ALT;  #1;
    chk("dec_sra", 32'(bus.alu_control), 32'h7);
    chk("dec_sra_stall", 32'(bus.stall), 32'd0);
    bus.funct7 = F7_BASE; #1;
    chk("dec_srl", 32'(bus.alu_control), 32'h6);
    bus.ALUOp = 2'b11; #1;
    chk("dec_err", 32'(bus.alu_control), 32'hF);
    chk("dec_err_stall", 32'(bus.stall), 32'd0);
    tick();
    chk("dec_no_done", 32'(bus.md_done), 32'd0);

    // Randomized decode sweep; MDU decodes kept invalid so no op starts.
    for (int i = 0; i < 30; i++) begin
      ra  = 2'($urandom_range(0, 3));
      rf3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       rf7 = F7_BASE;
        1:       rf7 = F7_ALT;
        default: rf7 = F7_MEXT;
      endcase
      ea = ref_alu(ra, rf3, rf7);
      bus.ALUOp = ra; bus.funct3 = rf3; bus.funct7 = rf7;
      bus.in_valid = (ea == 4'hA) ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      chk("dec_rand", 32'(bus.alu_control), 32'(ea));
      chk("dec_rand_stall", 32'(bus.stall), 32'd0);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();

    // Multiply with all-ones operands.
    md_op("mul",    3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT + 1);
    md_op("mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT + 1);
    md_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT + 1);
    md_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT + 1);

    // Divide directed values and corners.
    md_op("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, XLEN + 1);
    md_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, XLEN + 1);
    md_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, XLEN + 1);
    md_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, XLEN + 1);
    md_op("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, ref_lat(3'd5, 32'd5, 32'd0));
    md_op("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5, ref_lat(3'd7, 32'd5, 32'd0));
    md_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
          ref_lat(3'd4, 32'h8000_0000, 32'hFFFF_FFFF));
    md_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,
          ref_lat(3'd6, 32'h8000_0000, 32'hFFFF_FFFF));
    last_res = 32'd0;

    // Flush at t0+10 during a divide.
    drive_md(3'd4, 32'd1000, 32'd3);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) bus.in_valid = 1'b0;
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    chk("flush_stall", 32'(bus.stall), 32'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.md_done) ndone++;
    end
    chk("flush_no_done", 32'(ndone), 32'd0);
    chk("flush_keeps_result", bus.md_result, last_res);
    md_op("after_flush", 3'd4, 32'd1000, 32'd3, 32'd333, XLEN + 1);

    // Reset at t0+10 during a divide.
    drive_md(3'd6, 32'd1000, 32'd7);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) bus.in_valid = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("rst_mid_stall", 32'(bus.stall), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_mid_stall2", 32'(bus.stall), 32'd0);
    chk("rst_mid_result", bus.md_result, 32'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.md_done) ndone++;
    end
    chk("rst_no_done", 32'(ndone), 32'd0);
    md_op("after_rst", 3'd6, 32'd1000, 32'd7, 32'd6, XLEN + 1);

    // Back-to-back MUL then DIVU, second presented during DONE.
    drive_md(3'd0, 32'd3, 32'd5);
    ndone = 0;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (k == 1) bus.in_valid = 1'b0;
      #1;
      if (bus.md_done) ndone++;
      if (k == 3) begin
        chk("b2b_mul_done", 32'(bus.md_done), 32'd1);
        chk("b2b_mul_res", bus.md_result, 32'd15);
        drive_md(3'd5, 32'd100, 32'd7);
        #1;
        chk("b2b_done_nostart", 32'(bus.stall), 32'd0);
      end
      if (k == 4) chk("b2b_div_start", 32'(bus.stall), 32'd1);
      if (k == 5) bus.in_valid = 1'b0;
      if (k == 37) chk("b2b_div_done", 32'(bus.md_done), 32'd1);
    end
    chk("b2b_ndone", 32'(ndone), 32'd2);
    chk("b2b_div_res", bus.md_result, 32'd14);

    // Randomized MDU ops against the reference model.
    for (int i = 0; i < 12; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 300));
        default: ;
      endcase
      md_op("rand", rf3, a, b, ref_md(rf3, a, b), ref_lat(rf3, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
